// File: rtl/decode_issue_ctrl.sv
// Dual-issue decode front end: holds one fetch pair, resolves intra-pair RAW
// hazards and serializing instructions, and issues to the decoder pair.
module decode_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic        f_validB,
  input  logic [31:0] f_instA,
  input  logic [31:0] f_instB,
  input  logic [31:0] f_pcA,
  input  logic [31:0] f_pcB,
  output logic        f_ready,
  input  logic [1:0]  slots_free,
  input  logic        pipe_empty,
  input  logic        flush,
  output logic [31:0] d_instA,
  output logic [31:0] d_instB,
  output logic [31:0] d_pcA,
  output logic [31:0] d_pcB,
  output logic        d_validA,
  output logic        d_validB,
  output logic        serial_busy
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    B_ONLY = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_serial(input logic [6:0] op);
    return (op == OP_MISC) || (op == OP_SYSTEM);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
           (op == OP_IMM) || (op == OP_REG)   || (op == OP_LOAD);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  state_e      state_q, state_d;
  logic [31:0] instA_q, instB_q, pcA_q, pcB_q;
  logic        vB_q;

  logic [31:0] d_instA_q, d_instB_q, d_pcA_q, d_pcB_q;
  logic        d_validA_q, d_validB_q;

  logic        sf_ge1, sf_ge2;
  logic        serA, serB, hazard;
  logic        iss_a, iss_both, iss_b;
  logic        done, cap;

  // slots_free==3 saturates to 2, so ">=2" is just the MSB.
  assign sf_ge1 = |slots_free;
  assign sf_ge2 = slots_free[1];

  assign serA = is_serial(instA_q[6:0]);
  assign serB = is_serial(instB_q[6:0]);

  always_comb begin
    logic [4:0] rdA;
    rdA    = instA_q[11:7];
    hazard = vB_q && writes_rd(instA_q[6:0]) && (rdA != 5'd0) &&
             ((uses_rs1(instB_q[6:0]) && (rdA == instB_q[19:15])) ||
              (uses_rs2(instB_q[6:0]) && (rdA == instB_q[24:20])));
  end

  always_comb begin
    state_d  = state_q;
    iss_a    = 1'b0;
    iss_both = 1'b0;
    iss_b    = 1'b0;
    done     = 1'b0;
    case (state_q)
      HOLD: begin
        if (sf_ge1) begin
          if (serA) begin
            state_d = DRAIN;
          end else if (!vB_q) begin
            iss_a   = 1'b1;
            done    = 1'b1;
            state_d = EMPTY;
          end else if (sf_ge2 && !hazard && !serB) begin
            iss_both = 1'b1;
            done     = 1'b1;
            state_d  = EMPTY;
          end else begin
            iss_a   = 1'b1;
            state_d = B_ONLY;
          end
        end
      end
      DRAIN: begin
        if (sf_ge1 && pipe_empty) begin
          iss_a   = 1'b1;
          state_d = vB_q ? B_ONLY : EMPTY;
        end
      end
      B_ONLY: begin
        if (sf_ge1 && (!serB || pipe_empty)) begin
          iss_b   = 1'b1;
          done    = 1'b1;
          state_d = EMPTY;
        end
      end
      default: ;
    endcase

    f_ready = !rst && !flush && ((state_q == EMPTY) || done);
    cap     = f_valid && f_ready;
    // A new pair overrides the EMPTY transition so pairs can stream back to back.
    if (cap)   state_d = HOLD;
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      instA_q <= '0;
      instB_q <= '0;
      pcA_q   <= '0;
      pcB_q   <= '0;
      vB_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        instA_q <= '0;
        instB_q <= '0;
        pcA_q   <= '0;
        pcB_q   <= '0;
        vB_q    <= 1'b0;
      end else if (cap) begin
        instA_q <= f_instA;
        instB_q <= f_instB;
        pcA_q   <= f_pcA;
        pcB_q   <= f_pcB;
        vB_q    <= f_validB;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_instA_q  <= '0;
      d_instB_q  <= '0;
      d_pcA_q    <= '0;
      d_pcB_q    <= '0;
      d_validA_q <= 1'b0;
      d_validB_q <= 1'b0;
    end else begin
      d_validA_q <= !flush && (iss_a || iss_both || iss_b);
      d_validB_q <= !flush && iss_both;
      if (!flush && (iss_a || iss_both)) begin
        d_instA_q <= instA_q;
        d_pcA_q   <= pcA_q;
      end else if (!flush && iss_b) begin
        d_instA_q <= instB_q;
        d_pcA_q   <= pcB_q;
      end
      if (!flush && iss_both) begin
        d_instB_q <= instB_q;
        d_pcB_q   <= pcB_q;
      end
    end
  end

  assign d_instA     = d_instA_q;
  assign d_instB     = d_instB_q;
  assign d_pcA       = d_pcA_q;
  assign d_pcB       = d_pcB_q;
  assign d_validA    = d_validA_q;
  assign d_validB    = d_validB_q;
  assign serial_busy = (state_q == DRAIN);

endmodule
